// File: rtl/cipu_stream_tx.sv
// CIPU stream transmitter: buffers people/thing characters and segment pop counts, then plays them out.
// Latency: start sampled at edge t, ready_* during t+1, first characters from edge t+2; luggage pauses on ';' until done_thing.
module cipu_stream_tx #(
   parameter int DEPTH = 32,
   parameter int NUMQ  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_we,
   input  logic [1:0] load_sel,
   input  logic [7:0] load_data,
   input  logic       start,
   input  logic       done_thing,
   input  logic       done_fifo,
   input  logic       done_lifo,
   output logic       ready_fifo,
   output logic       ready_lifo,
   output logic [7:0] people_thing_in,
   output logic [7:0] thing_in,
   output logic [3:0] thing_num,
   output logic       busy,
   output logic       tx_done,
   output logic       err
);

   localparam int AW = $clog2(DEPTH);
   localparam int QW = $clog2(NUMQ);
   localparam logic [AW:0] BUF_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] BUF_ONE  = (AW+1)'(1);
   localparam logic [QW:0] Q_FULL   = (QW+1)'(NUMQ);
   localparam logic [QW:0] Q_ONE    = (QW+1)'(1);
   localparam logic [7:0]  CH_SEP   = 8'h3B;
   localparam logic [7:0]  CH_END   = 8'h24;

   typedef enum logic [2:0] {S_IDLE, S_ANNOUNCE, S_STREAM, S_DRAIN, S_FINISH} state_t;
   typedef enum logic [1:0] {T_SEND, T_PAUSE, T_DONE} tphase_t;

   state_t  state, state_nxt;
   tphase_t t_phase;

   logic [7:0] people_mem [DEPTH];
   logic [7:0] thing_mem  [DEPTH];
   logic [3:0] q_mem      [NUMQ];

   logic [AW:0] p_wr, p_rd, t_wr, t_rd;
   logic [QW:0] q_wr, q_rd, q_rd_eff;
   logic [7:0]  p_dat, t_dat, p_cur, t_cur;
   logic        p_done, fifo_seen, lifo_seen, err_q;
   logic        start_go, stream_en, load_ok, load_ovf, load_busy;
   logic        p_full, t_full, q_full, p_wen, t_wen, q_wen;
   logic        p_step, t_step, t_empty, q_empty, q_adv, t_sep_err;

   assign start_go  = (state == S_IDLE) && start;
   assign stream_en = (state == S_ANNOUNCE) || (state == S_STREAM);

   // Loads are only legal in IDLE, and a coincident start takes priority.
   assign load_ok   = load_we && (state == S_IDLE) && !start;
   assign load_busy = load_we && (state != S_IDLE);
   assign p_full    = (p_wr == BUF_FULL);
   assign t_full    = (t_wr == BUF_FULL);
   assign q_full    = (q_wr == Q_FULL);
   assign p_wen     = load_ok && (load_sel == 2'd0) && !p_full;
   assign t_wen     = load_ok && (load_sel == 2'd1) && !t_full;
   assign q_wen     = load_ok && (load_sel == 2'd2) && !q_full;
   assign load_ovf  = load_ok && (((load_sel == 2'd0) && p_full) ||
                                  ((load_sel == 2'd1) && t_full) ||
                                  ((load_sel == 2'd2) && q_full));

   assign p_cur   = people_mem[p_rd[AW-1:0]];
   assign t_cur   = thing_mem[t_rd[AW-1:0]];
   assign t_empty = (t_rd == t_wr);
   assign q_empty = (q_rd == q_wr);
   assign p_step  = stream_en && !p_done;
   assign t_step  = stream_en && ((t_phase == T_SEND) || ((t_phase == T_PAUSE) && done_thing));
   assign q_adv   = stream_en && (t_phase == T_PAUSE) && done_thing && !q_empty;
   assign q_rd_eff  = q_adv ? (q_rd + Q_ONE) : q_rd;
   assign t_sep_err = t_step && !t_empty && (t_cur == CH_SEP) && (q_rd_eff == q_wr);

   assign people_thing_in = p_dat;
   assign thing_in        = t_dat;
   assign thing_num       = ((state != S_IDLE) && !q_empty) ? q_mem[q_rd[QW-1:0]] : 4'd0;
   assign err             = err_q;

   always_ff @(posedge clk) begin
      if (p_wen) people_mem[p_wr[AW-1:0]] <= load_data;
      if (t_wen) thing_mem[t_wr[AW-1:0]]  <= load_data;
      if (q_wen) q_mem[q_wr[QW-1:0]]      <= load_data[3:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ready_fifo = 1'b0;
      ready_lifo = 1'b0;
      tx_done    = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE:     if (start) state_nxt = S_ANNOUNCE;
         S_ANNOUNCE: begin
            ready_fifo = 1'b1;
            ready_lifo = 1'b1;
            state_nxt  = S_STREAM;
         end
         S_STREAM:   if (p_done && (t_phase == T_DONE)) state_nxt = S_DRAIN;
         S_DRAIN:    if (fifo_seen && lifo_seen) state_nxt = S_FINISH;
         S_FINISH: begin
            tx_done   = 1'b1;
            state_nxt = S_IDLE;
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Write pointers, error flag and receiver done latches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_wr      <= '0;
         t_wr      <= '0;
         q_wr      <= '0;
         err_q     <= 1'b0;
         fifo_seen <= 1'b0;
         lifo_seen <= 1'b0;
      end else begin
         if (start_go) begin
            err_q     <= 1'b0;
            fifo_seen <= 1'b0;
            lifo_seen <= 1'b0;
         end else begin
            if (load_ovf || load_busy || t_sep_err) err_q <= 1'b1;
            if ((state != S_IDLE) && done_fifo) fifo_seen <= 1'b1;
            if ((state != S_IDLE) && done_lifo) lifo_seen <= 1'b1;
         end
         if (state == S_FINISH) begin
            p_wr <= '0;
            t_wr <= '0;
            q_wr <= '0;
         end else begin
            if (p_wen) p_wr <= p_wr + BUF_ONE;
            if (t_wen) t_wr <= t_wr + BUF_ONE;
            if (q_wen) q_wr <= q_wr + Q_ONE;
         end
      end
   end

   // People sub-stream: one character per cycle, auto '$' when the buffer runs dry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_rd   <= '0;
         p_done <= 1'b0;
         p_dat  <= 8'h00;
      end else if (start_go) begin
         p_rd   <= '0;
         p_done <= 1'b0;
         p_dat  <= 8'h00;
      end else if (p_step) begin
         if (p_rd == p_wr) begin
            p_dat  <= CH_END;
            p_done <= 1'b1;
         end else begin
            p_dat <= p_cur;
            p_rd  <= p_rd + BUF_ONE;
            if (p_cur == CH_END) p_done <= 1'b1;
         end
      end else begin
         p_dat <= 8'h00;
      end
   end

   // Thing sub-stream: the edge sampling done_thing in PAUSE also launches the next character.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_rd    <= '0;
         q_rd    <= '0;
         t_phase <= T_SEND;
         t_dat   <= 8'h00;
      end else if (start_go) begin
         t_rd    <= '0;
         q_rd    <= '0;
         t_phase <= T_SEND;
         t_dat   <= 8'h00;
      end else begin
         if (q_adv) q_rd <= q_rd + Q_ONE;
         if (t_step) begin
            if (t_empty) begin
               t_dat   <= CH_END;
               t_phase <= T_DONE;
            end else begin
               t_dat <= t_cur;
               t_rd  <= t_rd + BUF_ONE;
               if (t_cur == CH_SEP)      t_phase <= T_PAUSE;
               else if (t_cur == CH_END) t_phase <= T_DONE;
               else                      t_phase <= T_SEND;
            end
         end else begin
            t_dat <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_cipu_stream_tx.sv
// Scoreboard bench for cipu_stream_tx: loads push expected characters, the stream monitor pops and compares.
module tb_cipu_stream_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_we = 1'b0;
   logic [1:0] load_sel = 2'd0;
   logic [7:0] load_data = 8'h00;
   logic       start = 1'b0;
   logic       done_thing = 1'b0;
   logic       done_fifo = 1'b0;
   logic       done_lifo = 1'b0;
   logic       ready_fifo, ready_lifo, busy, tx_done, err;
   logic [7:0] people_thing_in, thing_in;
   logic [3:0] thing_num;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_p[$];
   logic [7:0] exp_t[$];
   logic [3:0] exp_n[$];

   always #5 clk = ~clk;

   cipu_stream_tx #(.DEPTH(32), .NUMQ(16)) dut (
      .clk(clk), .rst(rst), .load_we(load_we), .load_sel(load_sel), .load_data(load_data),
      .start(start), .done_thing(done_thing), .done_fifo(done_fifo), .done_lifo(done_lifo),
      .ready_fifo(ready_fifo), .ready_lifo(ready_lifo), .people_thing_in(people_thing_in),
      .thing_in(thing_in), .thing_num(thing_num), .busy(busy), .tx_done(tx_done), .err(err)
   );

   task automatic load_byte(input logic [1:0] sel, input logic [7:0] d);
      @(negedge clk);
      load_we = 1'b1; load_sel = sel; load_data = d;
      @(negedge clk);
      load_we = 1'b0;
   endtask

   task automatic load_str(input logic [1:0] sel, input string s);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         load_byte(sel, c);
         if (sel == 2'd0) exp_p.push_back(c); else exp_t.push_back(c);
      end
      if (c != 8'h24) begin
         if (sel == 2'd0) exp_p.push_back(8'h24); else exp_t.push_back(8'h24);
      end
   endtask

   task automatic check_err(input string tag, input logic want);
      n_tests++;
      if (err !== want) begin
         n_fail++;
         $display("FAIL %s err: got %b expected %b", tag, err, want);
      end
   endtask

   // Start, check announce, stream both sides against the scoreboard, then close out with done pulses.
   task automatic run_seq(input string tag, input int gap, input bit early_done,
                          input int busy_load_cyc, input bit collide);
      bit         p_fin, t_fin;
      int         pause_cnt;
      logic [3:0] held_num;
      logic [7:0] e;
      p_fin = 0; t_fin = 0; pause_cnt = 0; held_num = 4'd0;
      @(negedge clk);
      start = 1'b1;
      if (collide) begin load_we = 1'b1; load_sel = 2'd0; load_data = 8'h51; end
      @(negedge clk);
      start = 1'b0; load_we = 1'b0;
      n_tests++;
      if ({ready_fifo, ready_lifo, busy, people_thing_in, thing_in} !== {3'b111, 16'h0000}) begin
         n_fail++;
         $display("FAIL %s announce: got rdy=%b%b busy=%b p=%02h t=%02h expected rdy=11 busy=1 p=00 t=00",
                  tag, ready_fifo, ready_lifo, busy, people_thing_in, thing_in);
      end
      if (collide) check_err({tag, " collide"}, 1'b0);
      if (early_done) begin done_fifo = 1'b1; done_lifo = 1'b1; end
      for (int cyc = 0; cyc < 300 && !(p_fin && t_fin); cyc++) begin
         @(negedge clk);
         done_thing = 1'b0; load_we = 1'b0; done_fifo = 1'b0; done_lifo = 1'b0;
         e = p_fin ? 8'h00 : ((exp_p.size() != 0) ? exp_p.pop_front() : 8'h24);
         n_tests++;
         if (people_thing_in !== e) begin
            n_fail++;
            $display("FAIL %s people cyc%0d: got %02h expected %02h", tag, cyc, people_thing_in, e);
         end
         if (!p_fin && e == 8'h24) p_fin = 1;
         if (pause_cnt > 0) begin
            n_tests++;
            if ({thing_in, thing_num} !== {8'h00, held_num}) begin
               n_fail++;
               $display("FAIL %s pause cyc%0d: got t=%02h num=%0d expected t=00 num=%0d",
                        tag, cyc, thing_in, thing_num, held_num);
            end
            pause_cnt--;
            if (pause_cnt == 0) done_thing = 1'b1;
         end else begin
            e = t_fin ? 8'h00 : ((exp_t.size() != 0) ? exp_t.pop_front() : 8'h24);
            n_tests++;
            if (thing_in !== e) begin
               n_fail++;
               $display("FAIL %s thing cyc%0d: got %02h expected %02h", tag, cyc, thing_in, e);
            end
            if (!t_fin && e == 8'h3B) begin
               held_num = (exp_n.size() != 0) ? exp_n.pop_front() : 4'd0;
               pause_cnt = gap;
               n_tests++;
               if (thing_num !== held_num) begin
                  n_fail++;
                  $display("FAIL %s thing_num at sep: got %0d expected %0d", tag, thing_num, held_num);
               end
            end
            if (!t_fin && e == 8'h24) begin
               t_fin = 1;
               n_tests++;
               if (thing_num !== 4'd0) begin
                  n_fail++;
                  $display("FAIL %s thing_num at end: got %0d expected 0", tag, thing_num);
               end
            end
         end
         if (cyc == busy_load_cyc) begin load_we = 1'b1; load_sel = 2'd0; load_data = 8'h5A; end
      end
      if (!(p_fin && t_fin)) begin
         n_tests++; n_fail++;
         $display("FAIL %s stream timeout: got p_fin=%b t_fin=%b expected 11", tag, p_fin, t_fin);
      end
      load_we = 1'b0; done_thing = 1'b0;
      if (!early_done) begin done_fifo = 1'b1; done_lifo = 1'b1; end
      @(negedge clk);
      done_fifo = 1'b0; done_lifo = 1'b0;
      n_tests++;
      if ({tx_done, busy, people_thing_in, thing_in} !== {2'b01, 16'h0000}) begin
         n_fail++;
         $display("FAIL %s drain: got tx_done=%b busy=%b p=%02h t=%02h expected 0 1 00 00",
                  tag, tx_done, busy, people_thing_in, thing_in);
      end
      @(negedge clk);
      n_tests++;
      if ({tx_done, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL %s finish: got tx_done=%b busy=%b expected 1 1", tag, tx_done, busy);
      end
      @(negedge clk);
      n_tests++;
      if ({tx_done, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s idle: got tx_done=%b busy=%b expected 0 0", tag, tx_done, busy);
      end
      exp_p.delete(); exp_t.delete(); exp_n.delete();
   endtask

   task automatic test_reset;
      n_tests++;
      if ({ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num, busy, tx_done, err} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset outputs: got %b_%b_%02h_%02h_%0d_%b_%b_%b expected all zero", ready_fifo,
                  ready_lifo, people_thing_in, thing_in, thing_num, busy, tx_done, err);
      end
   endtask

   task automatic test_basic;
      load_str(2'd0, "AB$");
      load_str(2'd1, "12$");
      run_seq("basic", 0, 0, -1, 0);
      check_err("basic", 1'b0);
   endtask

   task automatic test_segment_pause;
      load_str(2'd1, "12;3$");
      exp_p.push_back(8'h24);
      load_byte(2'd2, 8'h01);
      load_byte(2'd2, 8'h00);
      exp_n.push_back(4'd1);
      run_seq("pause", 3, 0, -1, 0);
      check_err("pause", 1'b0);
   endtask

   task automatic test_auto_term;
      load_str(2'd1, "5");
      exp_p.push_back(8'h24);
      run_seq("autoterm", 0, 1, -1, 0);
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 33; i++) begin
         load_byte(2'd0, 8'(8'h40 + i));
         if (i < 32) exp_p.push_back(8'(8'h40 + i));
         if (i == 31) check_err("ovf 32 writes", 1'b0);
      end
      exp_p.push_back(8'h24);
      exp_t.push_back(8'h24);
      check_err("ovf 33 writes", 1'b1);
      run_seq("overflow", 0, 0, -1, 0);
   endtask

   task automatic test_busy_load;
      load_str(2'd0, "PQ$");
      load_str(2'd1, "RS$");
      run_seq("busyload", 0, 0, 1, 0);
      check_err("busyload", 1'b1);
   endtask

   task automatic test_underflow;
      load_str(2'd1, "1;2$");
      exp_p.push_back(8'h24);
      exp_n.push_back(4'd0);
      run_seq("underflow", 2, 0, -1, 0);
      check_err("underflow", 1'b1);
   endtask

   task automatic test_async_reset;
      load_str(2'd0, "AB$");
      load_str(2'd1, "CD$");
      exp_p.delete(); exp_t.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({people_thing_in, thing_in} !== 16'h4143) begin
         n_fail++;
         $display("FAIL arst pre: got p=%02h t=%02h expected 41 43", people_thing_in, thing_in);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if ({ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num, busy, tx_done, err} !== 25'd0) begin
         n_fail++;
         $display("FAIL arst outputs: got p=%02h t=%02h busy=%b expected all zero",
                  people_thing_in, thing_in, busy);
      end
      @(negedge clk); rst = 1'b1;
      exp_p.push_back(8'h24);
      exp_t.push_back(8'h24);
      run_seq("post_arst", 0, 0, -1, 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b1;
      test_basic();
      test_segment_pause();
      test_auto_term();
      test_overflow();
      test_busy_load();
      test_underflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cipu_stream_tx.md
# cipu_stream_tx

Stimulus-side transmitter for the CIPU character-stream protocol. Buffers a passenger/luggage character sequence and a queue of pop counts, then plays them out. The sequence is announced with ready_fifo/ready_lifo and sent as one character per cycle on people_thing_in and thing_in. The luggage stream pauses after each ';' segment separator until the receiver reports done_thing, and the block finishes once the receiver has reported done_fifo and done_lifo.

## Interface
- DEPTH, 32, capacity in characters of each stream buffer (people, thing)
- NUMQ, 16, capacity of the thing_num queue (one entry per segment)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load_we  in  1  write strobe for load_data
- load_sel  in  2  write target: 0 people buffer, 1 thing buffer, 2 thing_num queue (load_data[3:0]), 3 ignored
- load_data  in  8  character or count to append
- start  in  1  begin transmission (sampled in IDLE only)
- done_thing, done_fifo, done_lifo  in  1  receiver status pulses
- ready_fifo, ready_lifo  out  1  one-cycle announce pulse
- people_thing_in  out  8  people stream character
- thing_in  out  8  luggage stream character
- thing_num  out  4  pop count for the current segment
- busy  out  1  high from the start sample until tx_done
- tx_done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, cleared by start

## Operation
- Reset: all outputs 0, all write and read pointers 0, FSM in IDLE.
- Loading (IDLE only):
  - load_we appends to the selected buffer and advances its write pointer.
  - A write to a full buffer or queue is dropped and sets err.
  - load_we while busy is ignored and sets err.
- Top FSM: IDLE -> ANNOUNCE -> STREAM -> DRAIN -> FINISH -> IDLE.
- IDLE:
  - start=1 clears err, clears the read pointers and the done latches, and moves to ANNOUNCE.
- ANNOUNCE (1 cycle):
  - ready_fifo=ready_lifo=1; both data outputs 0x00.
- STREAM: people and thing sub-streams run independently.
- People sub-stream:
  - Outputs buf[rd] each cycle and advances rd.
  - When '$' (0x24) has been output it holds 0x00 and marks itself done.
  - If rd reaches the write pointer without a '$' having been sent, it emits '$' itself (auto-terminate).
- Thing sub-stream, SEND phase:
  - Outputs buf[rd] each cycle and advances rd.
  - thing_num always shows queue[qrd].
  - After outputting ';' (0x3B) it enters PAUSE.
  - After outputting '$' it enters DONE.
  - Auto-terminates with '$' exactly as the people sub-stream does.
- Thing sub-stream, PAUSE phase:
  - thing_in=0x00 and thing_num is held.
  - The edge that samples done_thing=1 advances qrd and returns to SEND; the next character is valid in the following cycle.
- DONE phase: thing_in=0x00.
- When ';' is output with the queue empty (qrd==qwr), thing_num=0 and err is set. The stream still proceeds.
- Non-special characters pass through unchanged: digits, letters and separators other than ';' and '$' are sent verbatim.
- STREAM -> DRAIN when both sub-streams are done.
- Done latches: done_fifo and done_lifo are latched on any cycle from ANNOUNCE onward, so early pulses are not lost.
- DRAIN -> FINISH once both latches are set.
- FINISH (1 cycle): tx_done=1, busy=0 next cycle; all write pointers cleared so the buffers are empty for the next sequence.
- Reset mid-operation: immediate return to the reset state; buffer contents are discarded logically because the pointers are zeroed.

## Timing
- Edge t samples start=1 -> ready_* high during cycle t+1 -> first characters valid during t+2 and sampled by the receiver at edge t+3.
- Character rate: one per cycle per stream while in SEND.
- Resume after a pause: done_thing high during cycle k (sampled at edge k+1) -> next thing character driven from edge k+1, held for one cycle.
- thing_num is stable from the cycle ';' is driven until the edge that samples done_thing.
- tx_done pulses in the cycle after the second done latch is set.
- busy drops on the edge after tx_done.
- Simultaneous start and load_we in IDLE: start wins, the write is dropped, and err stays clear.

## Test plan
- Basic announce/stream:
  - Stimulus: load people "AB$", thing "12$", start at edge 10.
  - Required response: ready_* high cycle 11; people 'A','B','$' cycles 12–14; thing '1','2','$' cycles 12–14; tx_done one cycle after done_fifo and done_lifo are both returned.
- Segment pause:
  - Stimulus: thing "12;3$", queue {1,0}; done_thing returned 3 cycles after ';'.
  - Required response: thing_num=1 during the pause; thing_in=0x00 during the pause; '3' driven the cycle after done_thing is sampled; thing_num=0 afterwards.
- Auto-terminate and empty buffer:
  - Stimulus: people empty, thing "5" with no '$'.
  - Required response: people '$' in the first data cycle; thing '5' then '$'.
- Overflow and busy load:
  - Stimulus: 33 writes to the people buffer with DEPTH=32.
  - Required response: err=1 and only 32 characters are sent.
  - Stimulus: load_we during STREAM.
  - Required response: err=1 and the streams are unaffected.
- Queue underflow:
  - Stimulus: thing "1;2$" with the queue empty.
  - Required response: thing_num=0 at ';', err=1, and '2' is still sent after done_thing.
- Async reset:
  - Stimulus: rst low mid-STREAM, between clock edges.
  - Required response: all outputs 0 immediately; start after release with an empty buffer yields '$' on both streams.
